unidade_busca: RTL and testbench

- Instruction-fetch and step-sequencing stage directly upstream of the processor control unit.
- Owns PC, memory address register (ADDR), data-out register (DOUT) and instruction register (IR).
- Drives the control unit's Instrucao and Tstep inputs, and consumes its Clear/IncrPc/ADDRin/DOUTin/W_D outputs.
- Inserts memory-latency wait cycles so the control unit only sees Tstep=01..11 once IR is valid.

---
 rtl/unidade_busca_pkg.sv | 35 +++
 rtl/unidade_busca_contador_pc.sv | 47 ++++
 rtl/unidade_busca.sv | 192 +++++++++++++++++++
 tb/tb_unidade_busca.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/unidade_busca_pkg.sv
// unidade_busca_pkg
// Shared definitions for the fetch/step-sequencing stage and the control unit
// that sits downstream of it: fetch FSM encoding, Tstep values, opcodes.
package unidade_busca_pkg;

  // Fetch/sequencing FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_ADDR = 3'd1,
    F_WAIT = 3'd2,
    F_LOAD = 3'd3,
    EXEC   = 3'd4
  } state_t;

  // Step counter values presented to the control unit.
  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b01;
  localparam logic [1:0] T2 = 2'b10;
  localparam logic [1:0] T3 = 2'b11;

  // Opcode field (IR[8:6]) shared with the control unit.
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  // Wait counter holds MEM_LAT, which is limited to 1..3.
  localparam int WAIT_W = 2;
  localparam logic [WAIT_W-1:0] WAIT_ONE = 2'd1;

endpackage

// File: rtl/unidade_busca_contador_pc.sv
// contador_pc
// Program counter with synchronous load and increment. Load has priority
// over increment; increment wraps from 2^ADDR_W-1 back to 0.
// Ports:
//   Clock, Resetn  - clock, synchronous active-low reset
//   load, load_val - load PC with load_val
//   incr           - PC <= PC + 1 (ignored when load is high)
//   pc             - current PC
module contador_pc #(
  parameter int ADDR_W   = 7,
  parameter int PC_RESET = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              incr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: load beats increment; wrap comes from the fixed width.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (incr) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pc_q <= ADDR_W'(PC_RESET);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca
// Instruction fetch and step sequencer in front of the control unit. Fetches
// the word at PC into IR (waiting MEM_LAT cycles for the synchronous memory),
// then counts Tstep 01..11 while the control unit executes. The control unit
// drives ADDR/DOUT/PC and write requests back through this block.
// Ports:
//   Clock, Resetn          - clock, synchronous active-low reset
//   Run                    - rising edge starts execution; held high keeps going
//   Clear, IncrPc, PcIn    - control unit sequencing / PC controls
//   ADDRin, DOUTin, W_D    - control unit memory access requests (EXEC only)
//   BusWires, MemData      - processor bus and memory read data
//   Addr, Dout, MemWr      - memory address, write data, write strobe
//   Instrucao, Tstep, Pc   - IR, step count and PC to the control unit
//   Busy                   - high whenever the FSM is not IDLE
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 7,
  parameter int INSTR_W  = 9,
  parameter int MEM_LAT  = 1,
  parameter int PC_RESET = 0
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Run,
  input  logic               Clear,
  input  logic               IncrPc,
  input  logic               PcIn,
  input  logic               ADDRin,
  input  logic               DOUTin,
  input  logic               W_D,
  input  logic [DATA_W-1:0]  BusWires,
  input  logic [DATA_W-1:0]  MemData,
  output logic [ADDR_W-1:0]  Addr,
  output logic [DATA_W-1:0]  Dout,
  output logic               MemWr,
  output logic [INSTR_W-1:0] Instrucao,
  output logic [1:0]         Tstep,
  output logic [ADDR_W-1:0]  Pc,
  output logic               Busy
);

  state_t             state_q, state_d;
  logic               run_d_q, run_d_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [1:0]         tstep_q, tstep_d;
  logic               mem_wr_q, mem_wr_d;
  logic               busy_q, busy_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               pc_load_s;
  logic               pc_incr_s;
  logic [ADDR_W-1:0]  pc_s;

  // Only the instruction field of the memory word is used by the fetch.
  logic unused_mem_s;
  assign unused_mem_s = ^MemData[DATA_W-1:INSTR_W];

  contador_pc #(
    .ADDR_W  (ADDR_W),
    .PC_RESET(PC_RESET)
  ) u_pc (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .load    (pc_load_s),
    .load_val(BusWires[ADDR_W-1:0]),
    .incr    (pc_incr_s),
    .pc      (pc_s)
  );

  // Next-state and register-update logic for the fetch/step FSM.
  always_comb begin
    state_d   = state_q;
    run_d_d   = Run;
    addr_d    = addr_q;
    dout_d    = dout_q;
    ir_d      = ir_q;
    tstep_d   = T0;
    mem_wr_d  = 1'b0;
    wait_d    = wait_q;
    pc_incr_s = 1'b0;

    // PcIn may redirect the PC in any active state, even mid-fetch.
    if (state_q != IDLE) begin
      pc_load_s = PcIn;
    end else begin
      pc_load_s = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (Run && !run_d_q) begin
          state_d = F_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      F_ADDR: begin
        addr_d  = pc_s;
        wait_d  = WAIT_W'(MEM_LAT);
        state_d = F_WAIT;
      end
      F_WAIT: begin
        wait_d = wait_q - WAIT_ONE;
        // Leave after exactly MEM_LAT cycles here.
        if (wait_q <= WAIT_ONE) begin
          state_d = F_LOAD;
        end else begin
          state_d = F_WAIT;
        end
      end
      F_LOAD: begin
        ir_d      = MemData[INSTR_W-1:0];
        pc_incr_s = 1'b1;
        tstep_d   = T1;
        state_d   = EXEC;
      end
      EXEC: begin
        pc_incr_s = IncrPc;
        mem_wr_d  = W_D;
        if (ADDRin) begin
          addr_d = BusWires[ADDR_W-1:0];
        end else begin
          addr_d = addr_q;
        end
        if (DOUTin) begin
          dout_d = BusWires;
        end else begin
          dout_d = dout_q;
        end
        if (Clear) begin
          tstep_d = T0;
          if (Run) begin
            state_d = F_ADDR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          // Saturate at T3 for instructions needing no further steps.
          if (tstep_q == T3) begin
            tstep_d = T3;
          end else begin
            tstep_d = tstep_q + 2'd1;
          end
          state_d = EXEC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset overrides everything, including
  // a write strobe that would otherwise fire on this edge.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      run_d_q  <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      dout_q   <= {DATA_W{1'b0}};
      ir_q     <= {INSTR_W{1'b0}};
      tstep_q  <= T0;
      mem_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      wait_q   <= {WAIT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      run_d_q  <= run_d_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      ir_q     <= ir_d;
      tstep_q  <= tstep_d;
      mem_wr_q <= mem_wr_d;
      busy_q   <= busy_d;
      wait_q   <= wait_d;
    end
  end

  assign Addr      = addr_q;
  assign Dout      = dout_q;
  assign MemWr     = mem_wr_q;
  assign Instrucao = ir_q;
  assign Tstep     = tstep_q;
  assign Pc        = pc_s;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_unidade_busca.sv
module tb_unidade_busca;

  logic        Clock = 1'b0;
  logic        Resetn, Run, Clear, IncrPc, PcIn, ADDRin, DOUTin, W_D;
  logic [15:0] BusWires, MemData;
  logic [6:0]  Addr, Pc;
  logic [15:0] Dout;
  logic        MemWr, Busy;
  logic [8:0]  Instrucao;
  logic [1:0]  Tstep;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  unidade_busca dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Clear(Clear),
    .IncrPc(IncrPc), .PcIn(PcIn), .ADDRin(ADDRin), .DOUTin(DOUTin),
    .W_D(W_D), .BusWires(BusWires), .MemData(MemData), .Addr(Addr),
    .Dout(Dout), .MemWr(MemWr), .Instrucao(Instrucao), .Tstep(Tstep),
    .Pc(Pc), .Busy(Busy)
  );

  // Memory with one cycle of synchronous read latency.
  logic [15:0] mem [128];
  always @(posedge Clock) begin
    MemData <= mem[Addr];
    if (MemWr === 1'b1) mem[Addr] <= Dout;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected memory writes: {addr, data}.
  logic [22:0] sb_q [$];
  always @(negedge Clock) begin
    if (MemWr === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("memwr_unexpected", 32'(MemWr), 32'd0);
      end else begin
        logic [22:0] e;
        e = sb_q.pop_front();
        chk("sb_addr", 32'(Addr), 32'(e[22:16]));
        chk("sb_dout", 32'(Dout), 32'(e[15:0]));
      end
    end
  end

  typedef struct {
    logic run, clr, inc, pcin, ain, din, wd;
    logic [15:0] bus;
    logic [1:0]  t;
    logic [6:0]  pc, addr;
    logic [15:0] dout;
    logic [8:0]  ir;
    logic        busy, mw;
  } vec_t;

  function automatic vec_t mk(input logic run, clr, inc, pcin, ain, din, wd,
                              input logic [15:0] bus, input logic [1:0] t,
                              input logic [6:0] pc, addr, input logic [15:0] dout,
                              input logic [8:0] ir, input logic busy, mw);
    vec_t v;
    v.run = run; v.clr = clr; v.inc = inc; v.pcin = pcin; v.ain = ain;
    v.din = din; v.wd = wd; v.bus = bus; v.t = t; v.pc = pc; v.addr = addr;
    v.dout = dout; v.ir = ir; v.busy = busy; v.mw = mw;
    return v;
  endfunction

  task automatic drive(input logic run, clr, inc, pcin, ain, din, wd, input logic [15:0] bus);
    Run = run; Clear = clr; IncrPc = inc; PcIn = pcin; ADDRin = ain;
    DOUTin = din; W_D = wd; BusWires = bus;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tstep"}, 32'(Tstep), 32'd0);
    chk({tag, "_pc"}, 32'(Pc), 32'd0);
    chk({tag, "_addr"}, 32'(Addr), 32'd0);
    chk({tag, "_dout"}, 32'(Dout), 32'd0);
    chk({tag, "_ir"}, 32'(Instrucao), 32'd0);
    chk({tag, "_memwr"}, 32'(MemWr), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  vec_t vecs [25];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h0040;
    mem[1] = 16'hF1A5;

    //              run clr inc pin ain din wd  bus       t  pc    addr  dout      ir      busy mw
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd0,   7'd0,  16'h0000, 9'h000, 1, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd0,   7'd0,  16'h0000, 9'h000, 1, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd0,   7'd0,  16'h0000, 9'h000, 1, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd1, 7'd1,   7'd0,  16'h0000, 9'h040, 1, 0);
    vecs[4]  = mk(1, 1, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd1,   7'd0,  16'h0000, 9'h040, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd1,   7'd1,  16'h0000, 9'h040, 1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd1,   7'd1,  16'h0000, 9'h040, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd1, 7'd2,   7'd1,  16'h0000, 9'h1A5, 1, 0);
    vecs[8]  = mk(1, 0, 0, 0, 1, 0, 0, 16'h0005, 2'd2, 7'd2,   7'd5,  16'h0000, 9'h1A5, 1, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 1, 0, 16'h00AB, 2'd3, 7'd2,   7'd5,  16'h00AB, 9'h1A5, 1, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, 2'd3, 7'd2,   7'd5,  16'h00AB, 9'h1A5, 1, 1);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd3, 7'd2,   7'd5,  16'h00AB, 9'h1A5, 1, 0);
    vecs[12] = mk(1, 1, 1, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd3,   7'd5,  16'h00AB, 9'h1A5, 1, 0);
    vecs[13] = mk(1, 0, 0, 1, 0, 0, 0, 16'h007F, 2'd0, 7'd127, 7'd3,  16'h00AB, 9'h1A5, 1, 0);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd127, 7'd3,  16'h00AB, 9'h1A5, 1, 0);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd1, 7'd0,   7'd3,  16'h00AB, 9'h003, 1, 0);
    vecs[16] = mk(1, 0, 1, 1, 0, 0, 0, 16'h0010, 2'd2, 7'd16,  7'd3,  16'h00AB, 9'h003, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd3, 7'd16,  7'd3,  16'h00AB, 9'h003, 1, 0);
    vecs[18] = mk(0, 1, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd16,  7'd3,  16'h00AB, 9'h003, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd16,  7'd3,  16'h00AB, 9'h003, 0, 0);
    vecs[20] = mk(0, 1, 1, 1, 1, 1, 1, 16'h0033, 2'd0, 7'd16,  7'd3,  16'h00AB, 9'h003, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd16,  7'd3,  16'h00AB, 9'h003, 1, 0);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd16,  7'd16, 16'h00AB, 9'h003, 1, 0);
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 7'd16,  7'd16, 16'h00AB, 9'h003, 1, 0);
    vecs[24] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 2'd1, 7'd17,  7'd16, 16'h00AB, 9'h010, 1, 0);

    // Reset
    Resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0000);
    repeat (2) @(posedge Clock);
    #1;
    chk_reset_state("reset");

    // Table-driven main sequence
    @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].run, vecs[i].clr, vecs[i].inc, vecs[i].pcin,
            vecs[i].ain, vecs[i].din, vecs[i].wd, vecs[i].bus);
      if (vecs[i].mw) sb_q.push_back({vecs[i].addr, vecs[i].dout});
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d_tstep", i), 32'(Tstep), 32'(vecs[i].t));
      chk($sformatf("v%0d_pc", i), 32'(Pc), 32'(vecs[i].pc));
      chk($sformatf("v%0d_addr", i), 32'(Addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_dout", i), 32'(Dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d_ir", i), 32'(Instrucao), 32'(vecs[i].ir));
      chk($sformatf("v%0d_busy", i), 32'(Busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_memwr", i), 32'(MemWr), 32'(vecs[i].mw));
      @(negedge Clock);
    end

    // Reset during F_WAIT: Clear with Run -> F_ADDR, then F_WAIT, then reset
    drive(1, 1, 0, 0, 0, 0, 0, 16'h0000);
    @(posedge Clock);
    @(negedge Clock);
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0000);
    @(posedge Clock);
    #1;
    chk("fwait_addr", 32'(Addr), 32'd17);
    chk("fwait_busy", 32'(Busy), 32'd1);
    @(negedge Clock);
    Resetn = 1'b0;
    @(posedge Clock);
    #1;
    chk_reset_state("rst_fwait");

    // Reset in EXEC with a write requested: the write is dropped
    @(negedge Clock);
    Resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0000);
    @(negedge Clock);
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0000);
    repeat (4) @(posedge Clock);
    #1;
    chk("refetch_tstep", 32'(Tstep), 32'd1);
    chk("refetch_ir", 32'(Instrucao), 32'h040);
    chk("refetch_pc", 32'(Pc), 32'd1);
    @(negedge Clock);
    Resetn = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 1, 16'h0000);
    @(posedge Clock);
    #1;
    chk_reset_state("rst_exec");
    @(negedge Clock);
    Resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0000);
    @(posedge Clock);
    #1;
    chk("post_rst_memwr", 32'(MemWr), 32'd0);
    chk("post_rst_busy", 32'(Busy), 32'd0);

    @(negedge Clock);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
